pipe_hazard_ctrl: RTL and testbench

- Sequences the IF, IF/ID and ID/EX pipeline registers of the 5-stage MIPS core.
- Decides each cycle whether the front end advances, holds (data hazard), flushes (taken branch) or fully freezes (multi-cycle data-memory access).
- Keeps saturating performance counters and a sticky memory-timeout flag.
- Sits beside the ID stage; its control outputs drive the PC register, IF/ID register and ID/EX register enables/clears.

---
 rtl/pipe_hazard_ctrl_if.sv | 62 ++++++
 rtl/pipe_hazard_ctrl.sv | 166 ++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 372 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_hazard_ctrl_if.sv
// Signal bundle between the ID-stage hazard controller and the pipeline
// around it. The pipeline side (master) supplies the register indices,
// stage controls and the data-memory handshake. The controller (slave)
// returns the register enables/clears, the counters and its FSM state.
//
// Memory handshake: the MEM stage holds mem_req high for the whole access.
// The access completes in the cycle where mem_req and mem_ready are both
// high. mem_ready with mem_req low means nothing. While an access is
// outstanding the controller freezes the pipeline, so the MEM stage keeps
// presenting the same request.
interface pipe_hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  // ID-stage operands
  logic [4:0]       id_src1;
  logic [4:0]       id_src2;
  logic             id_two_src;
  logic             id_valid;
  // EXE-stage producer
  logic [4:0]       exe_dest;
  logic             exe_wb_en;
  logic             exe_mem_r_en;
  // MEM-stage producer
  logic [4:0]       mem_dest;
  logic             mem_wb_en;
  // branch resolution and memory handshake
  logic             br_taken;
  logic             mem_req;
  logic             mem_ready;
  logic             cnt_clr;
  // register controls
  logic             pc_hold;
  logic             ifid_hold;
  logic             ifid_flush;
  logic             idex_bubble;
  logic             freeze;
  // status
  logic             mem_timeout;
  logic [CNT_W-1:0] cnt_stall;
  logic [CNT_W-1:0] cnt_flush;
  logic [CNT_W-1:0] cnt_memwait;
  // FSM state: 0 = RUN, 1 = MEM_WAIT
  logic             state_dbg;

  modport master (
    output id_src1, id_src2, id_two_src, id_valid,
    output exe_dest, exe_wb_en, exe_mem_r_en,
    output mem_dest, mem_wb_en,
    output br_taken, mem_req, mem_ready, cnt_clr,
    input  pc_hold, ifid_hold, ifid_flush, idex_bubble, freeze,
    input  mem_timeout, cnt_stall, cnt_flush, cnt_memwait, state_dbg
  );

  modport slave (
    input  id_src1, id_src2, id_two_src, id_valid,
    input  exe_dest, exe_wb_en, exe_mem_r_en,
    input  mem_dest, mem_wb_en,
    input  br_taken, mem_req, mem_ready, cnt_clr,
    output pc_hold, ifid_hold, ifid_flush, idex_bubble, freeze,
    output mem_timeout, cnt_stall, cnt_flush, cnt_memwait, state_dbg
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Front-end sequencer for the 5-stage MIPS pipeline. Each cycle it decides
// whether PC, IF/ID and ID/EX advance, hold on a data hazard, flush on a
// taken branch, or freeze on a multi-cycle data-memory access.
// Priority: memory wait > branch flush > data hazard.
// Control outputs are combinational and forced low while rst is low.
// The counters and the sticky timeout flag are registered.
module pipe_hazard_ctrl #(
  parameter bit FWD_EN      = 1'b1,
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 16
) (
  input logic               clk,
  input logic               rst,
  pipe_hazard_ctrl_if.slave bus
);

  typedef enum logic {
    ST_RUN      = 1'b0,
    ST_MEM_WAIT = 1'b1
  } state_t;

  localparam int               WAIT_W    = 16;
  // A wait counter equal to WAIT_LAST marks the MEM_TIMEOUT-th MEM_WAIT cycle.
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]  CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t            state_q, state_nxt;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_nxt;
  logic              tmo_q;
  logic              tmo_set;

  logic              exe_match, mem_match, hazard;
  logic              src1_used, src2_used;

  logic              pc_hold_c, ifid_hold_c, ifid_flush_c, idex_bubble_c, freeze_c;
  logic              stall_ev;

  logic [CNT_W-1:0]  cnt_stall_q, cnt_flush_q, cnt_memwait_q;

  // RAW detection between the ID sources and the EXE/MEM destinations.
  // Register 0 is never a real dependency.
  always_comb begin
    src1_used = bus.id_valid;
    src2_used = bus.id_valid & bus.id_two_src;
    exe_match = (bus.exe_dest != 5'd0) &&
                ((src1_used && (bus.id_src1 == bus.exe_dest)) ||
                 (src2_used && (bus.id_src2 == bus.exe_dest)));
    mem_match = (bus.mem_dest != 5'd0) &&
                ((src1_used && (bus.id_src1 == bus.mem_dest)) ||
                 (src2_used && (bus.id_src2 == bus.mem_dest)));
    if (FWD_EN) begin
      // Forwarding covers every case except a load whose data is not ready yet.
      hazard = exe_match & bus.exe_mem_r_en;
    end else begin
      hazard = (exe_match & bus.exe_wb_en) | (mem_match & bus.mem_wb_en);
    end
  end

  // Next state, wait counter and raw control outputs.
  always_comb begin
    state_nxt     = state_q;
    wait_cnt_nxt  = wait_cnt_q;
    tmo_set       = 1'b0;
    pc_hold_c     = 1'b0;
    ifid_hold_c   = 1'b0;
    ifid_flush_c  = 1'b0;
    idex_bubble_c = 1'b0;
    freeze_c      = 1'b0;
    stall_ev      = 1'b0;
    unique case (state_q)
      ST_RUN: begin
        if (bus.mem_req && !bus.mem_ready) begin
          // First cycle of a slow access: freeze now and start counting.
          state_nxt    = ST_MEM_WAIT;
          wait_cnt_nxt = '0;
          freeze_c     = 1'b1;
          pc_hold_c    = 1'b1;
          ifid_hold_c  = 1'b1;
        end else if (bus.br_taken) begin
          // PC loads the target; the wrong-path instructions become NOPs.
          ifid_flush_c  = 1'b1;
          idex_bubble_c = 1'b1;
        end else if (hazard) begin
          pc_hold_c     = 1'b1;
          ifid_hold_c   = 1'b1;
          idex_bubble_c = 1'b1;
          stall_ev      = 1'b1;
        end
      end
      ST_MEM_WAIT: begin
        // The whole pipeline is frozen, so branch and hazard inputs are stale.
        freeze_c     = 1'b1;
        pc_hold_c    = 1'b1;
        ifid_hold_c  = 1'b1;
        wait_cnt_nxt = wait_cnt_q + 16'd1;
        if (bus.mem_ready) begin
          state_nxt = ST_RUN;
        end else if (wait_cnt_q == WAIT_LAST) begin
          tmo_set   = 1'b1;
          state_nxt = ST_RUN;
        end
      end
      default: begin
        state_nxt = ST_RUN;
      end
    endcase
  end

  // FSM state and wait counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_RUN;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_nxt;
      wait_cnt_q <= wait_cnt_nxt;
    end
  end

  // Sticky timeout flag: set by a timed-out access, cleared only by reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tmo_q <= 1'b0;
    end else if (tmo_set) begin
      tmo_q <= 1'b1;
    end
  end

  // Saturating performance counters. A clear wins over an increment.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_stall_q   <= '0;
      cnt_flush_q   <= '0;
      cnt_memwait_q <= '0;
    end else if (bus.cnt_clr) begin
      cnt_stall_q   <= '0;
      cnt_flush_q   <= '0;
      cnt_memwait_q <= '0;
    end else begin
      if (stall_ev && (cnt_stall_q != CNT_MAX)) begin
        cnt_stall_q <= cnt_stall_q + CNT_ONE;
      end
      if (ifid_flush_c && (cnt_flush_q != CNT_MAX)) begin
        cnt_flush_q <= cnt_flush_q + CNT_ONE;
      end
      if (freeze_c && (cnt_memwait_q != CNT_MAX)) begin
        cnt_memwait_q <= cnt_memwait_q + CNT_ONE;
      end
    end
  end

  // Control outputs stay low while reset is asserted, whatever the inputs do.
  assign bus.pc_hold     = rst & pc_hold_c;
  assign bus.ifid_hold   = rst & ifid_hold_c;
  assign bus.ifid_flush  = rst & ifid_flush_c;
  assign bus.idex_bubble = rst & idex_bubble_c;
  assign bus.freeze      = rst & freeze_c;

  assign bus.mem_timeout = tmo_q;
  assign bus.cnt_stall   = cnt_stall_q;
  assign bus.cnt_flush   = cnt_flush_q;
  assign bus.cnt_memwait = cnt_memwait_q;
  assign bus.state_dbg   = state_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl. Two instances see identical stimulus:
//   cfg 0: FWD_EN=1, MEM_TIMEOUT=4, CNT_W=4  (load-use only, short timeout, small counters)
//   cfg 1: FWD_EN=0, MEM_TIMEOUT=7, CNT_W=16 (stall on any RAW against EXE/MEM)
// Directed scenarios run first, then randomized traffic. A behavioural
// reference model checks every cycle.
module tb_pipe_hazard_ctrl;

  localparam int CW0 = 4;
  localparam int CW1 = 16;

  typedef struct packed {
    logic       rst;
    logic [4:0] id_src1;
    logic [4:0] id_src2;
    logic       id_two_src;
    logic       id_valid;
    logic [4:0] exe_dest;
    logic       exe_wb_en;
    logic       exe_mem_r_en;
    logic [4:0] mem_dest;
    logic       mem_wb_en;
    logic       br_taken;
    logic       mem_req;
    logic       mem_ready;
    logic       cnt_clr;
  } stim_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  pipe_hazard_ctrl_if #(.CNT_W(CW0)) bus0 ();
  pipe_hazard_ctrl_if #(.CNT_W(CW1)) bus1 ();

  pipe_hazard_ctrl #(.FWD_EN(1'b1), .MEM_TIMEOUT(4), .CNT_W(CW0)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  pipe_hazard_ctrl #(.FWD_EN(1'b0), .MEM_TIMEOUT(7), .CNT_W(CW1)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [5:0] exp_q[$];

  // reference model state, one slot per configuration
  bit m_wait[2];
  int m_waited[2];
  bit m_tmo[2];
  int m_stall[2];
  int m_flush[2];
  int m_mw[2];

  function automatic bit cfg_fwd(input int c);
    return (c == 0);
  endfunction

  function automatic int cfg_tmo(input int c);
    return (c == 0) ? 4 : 7;
  endfunction

  function automatic int cfg_max(input int c);
    return (c == 0) ? 15 : 65535;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end else begin
      n_pass++;
    end
  endtask

  // ---------------- observation helpers ----------------
  function automatic logic [5:0] obs_ctrl(input int c);
    if (c == 0) return {bus0.state_dbg, bus0.pc_hold, bus0.ifid_hold, bus0.ifid_flush, bus0.idex_bubble, bus0.freeze};
    return {bus1.state_dbg, bus1.pc_hold, bus1.ifid_hold, bus1.ifid_flush, bus1.idex_bubble, bus1.freeze};
  endfunction

  function automatic logic [31:0] obs_stall(input int c);
    return (c == 0) ? 32'(bus0.cnt_stall) : 32'(bus1.cnt_stall);
  endfunction

  function automatic logic [31:0] obs_flush(input int c);
    return (c == 0) ? 32'(bus0.cnt_flush) : 32'(bus1.cnt_flush);
  endfunction

  function automatic logic [31:0] obs_mw(input int c);
    return (c == 0) ? 32'(bus0.cnt_memwait) : 32'(bus1.cnt_memwait);
  endfunction

  function automatic logic [31:0] obs_tmo(input int c);
    return (c == 0) ? 32'(bus0.mem_timeout) : 32'(bus1.mem_timeout);
  endfunction

  // ---------------- reference model ----------------
  task automatic model_reset(input int c);
    m_wait[c]   = 1'b0;
    m_waited[c] = 0;
    m_tmo[c]    = 1'b0;
    m_stall[c]  = 0;
    m_flush[c]  = 0;
    m_mw[c]     = 0;
  endtask

  // Collect the sources the ID instruction really reads, then look for a
  // nonzero one that a relevant producer is about to write.
  function automatic bit model_hazard(input int c, input stim_t s);
    logic [4:0] srcs[$];
    bit hit = 1'b0;
    if (s.id_valid) srcs.push_back(s.id_src1);
    if (s.id_valid && s.id_two_src) srcs.push_back(s.id_src2);
    foreach (srcs[i]) begin
      if (srcs[i] != 5'd0) begin
        if (cfg_fwd(c)) begin
          if (s.exe_mem_r_en && srcs[i] == s.exe_dest) hit = 1'b1;
        end else begin
          if (s.exe_wb_en && srcs[i] == s.exe_dest) hit = 1'b1;
          if (s.mem_wb_en && srcs[i] == s.mem_dest) hit = 1'b1;
        end
      end
    end
    return hit;
  endfunction

  function automatic int sat_inc(input int v, input int mx);
    return (v >= mx) ? mx : v + 1;
  endfunction

  // One cycle of the model for configuration c: check registered state,
  // predict the combinational controls, check them, then advance.
  task automatic model_step(input int c, input stim_t s);
    bit pc = 0, ifid = 0, fl = 0, bub = 0, frz = 0, stall = 0;
    bit was_wait;
    if (!s.rst) model_reset(c);
    check($sformatf("c%0d cnt_stall", c), obs_stall(c), m_stall[c]);
    check($sformatf("c%0d cnt_flush", c), obs_flush(c), m_flush[c]);
    check($sformatf("c%0d cnt_memwait", c), obs_mw(c), m_mw[c]);
    check($sformatf("c%0d mem_timeout", c), obs_tmo(c), 32'(m_tmo[c]));
    was_wait = m_wait[c];
    if (s.rst) begin
      if (m_wait[c]) begin
        pc = 1; ifid = 1; frz = 1;
        if (s.mem_ready) begin
          m_wait[c] = 1'b0;
        end else begin
          m_waited[c]++;
          if (m_waited[c] == cfg_tmo(c)) begin
            m_tmo[c]  = 1'b1;
            m_wait[c] = 1'b0;
          end
        end
      end else if (s.mem_req && !s.mem_ready) begin
        pc = 1; ifid = 1; frz = 1;
        m_wait[c]   = 1'b1;
        m_waited[c] = 0;
      end else if (s.br_taken) begin
        fl = 1; bub = 1;
      end else if (model_hazard(c, s)) begin
        pc = 1; ifid = 1; bub = 1; stall = 1;
      end
    end
    exp_q.push_back({was_wait, pc, ifid, fl, bub, frz});
    check($sformatf("c%0d ctrl{st,pc,ifid,fl,bub,frz}", c), 32'(obs_ctrl(c)), 32'(exp_q.pop_front()));
    if (s.rst) begin
      if (s.cnt_clr) begin
        m_stall[c] = 0; m_flush[c] = 0; m_mw[c] = 0;
      end else begin
        if (stall) m_stall[c] = sat_inc(m_stall[c], cfg_max(c));
        if (fl)    m_flush[c] = sat_inc(m_flush[c], cfg_max(c));
        if (frz)   m_mw[c]    = sat_inc(m_mw[c], cfg_max(c));
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  function automatic stim_t idle();
    stim_t s = '0;
    s.rst = 1'b1;
    return s;
  endfunction

  task automatic drive(input stim_t s);
    rst               = s.rst;
    bus0.id_src1      = s.id_src1;      bus1.id_src1      = s.id_src1;
    bus0.id_src2      = s.id_src2;      bus1.id_src2      = s.id_src2;
    bus0.id_two_src   = s.id_two_src;   bus1.id_two_src   = s.id_two_src;
    bus0.id_valid     = s.id_valid;     bus1.id_valid     = s.id_valid;
    bus0.exe_dest     = s.exe_dest;     bus1.exe_dest     = s.exe_dest;
    bus0.exe_wb_en    = s.exe_wb_en;    bus1.exe_wb_en    = s.exe_wb_en;
    bus0.exe_mem_r_en = s.exe_mem_r_en; bus1.exe_mem_r_en = s.exe_mem_r_en;
    bus0.mem_dest     = s.mem_dest;     bus1.mem_dest     = s.mem_dest;
    bus0.mem_wb_en    = s.mem_wb_en;    bus1.mem_wb_en    = s.mem_wb_en;
    bus0.br_taken     = s.br_taken;     bus1.br_taken     = s.br_taken;
    bus0.mem_req      = s.mem_req;      bus1.mem_req      = s.mem_req;
    bus0.mem_ready    = s.mem_ready;    bus1.mem_ready    = s.mem_ready;
    bus0.cnt_clr      = s.cnt_clr;      bus1.cnt_clr      = s.cnt_clr;
  endtask

  // Apply one cycle of stimulus on the falling edge and check just after it.
  task automatic cycle(input stim_t s);
    @(negedge clk);
    drive(s);
    #1;
    model_step(0, s);
    model_step(1, s);
  endtask

  function automatic stim_t load_use(input logic [4:0] r);
    stim_t s = idle();
    s.exe_mem_r_en = 1'b1;
    s.exe_wb_en    = 1'b1;
    s.exe_dest     = r;
    s.id_src1      = r;
    s.id_valid     = 1'b1;
    return s;
  endfunction

  function automatic stim_t rand_stim();
    stim_t s;
    s.rst          = ($urandom_range(0, 199) != 0);
    s.id_src1      = 5'($urandom_range(0, 3));
    s.id_src2      = 5'($urandom_range(0, 3));
    s.id_two_src   = 1'($urandom);
    s.id_valid     = ($urandom_range(0, 3) != 0);
    s.exe_dest     = 5'($urandom_range(0, 3));
    s.exe_wb_en    = 1'($urandom);
    s.exe_mem_r_en = 1'($urandom);
    s.mem_dest     = 5'($urandom_range(0, 3));
    s.mem_wb_en    = 1'($urandom);
    s.br_taken     = ($urandom_range(0, 3) == 0);
    s.mem_req      = 1'($urandom);
    s.mem_ready    = ($urandom_range(0, 2) == 0);
    s.cnt_clr      = ($urandom_range(0, 39) == 0);
    return s;
  endfunction

  // ---------------- watchdog ----------------
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    stim_t s;
    model_reset(0);
    model_reset(1);
    drive(idle());
    rst = 1'b0;

    // reset: all controls and counters low even with a request pending
    s = idle(); s.rst = 1'b0; s.mem_req = 1'b1; s.br_taken = 1'b1;
    cycle(s);
    check("rst freeze", 32'(bus0.freeze), 0);
    check("rst ifid_flush", 32'(bus1.ifid_flush), 0);
    cycle(idle());

    // load-use, producer in EXE then moving to MEM
    cycle(load_use(5'd5));
    check("lu c0 pc_hold", 32'(bus0.pc_hold), 1);
    check("lu c0 idex_bubble", 32'(bus0.idex_bubble), 1);
    s = idle(); s.id_src1 = 5'd5; s.id_valid = 1'b1; s.mem_dest = 5'd5; s.mem_wb_en = 1'b1;
    cycle(s);
    check("lu next c0 pc_hold", 32'(bus0.pc_hold), 0);
    check("lu next c1 pc_hold", 32'(bus1.pc_hold), 1);
    cycle(idle());
    check("lu c0 cnt_stall", bus0.cnt_stall, 1);
    check("lu c1 cnt_stall", bus1.cnt_stall, 2);
    cycle(load_use(5'd0));
    check("lu r0 c0 pc_hold", 32'(bus0.pc_hold), 0);

    // RAW on src2 against MEM
    s = idle(); s.mem_wb_en = 1'b1; s.mem_dest = 5'd7; s.id_src2 = 5'd7;
    s.id_two_src = 1'b1; s.id_valid = 1'b1;
    cycle(s);
    check("raw c1 pc_hold", 32'(bus1.pc_hold), 1);
    check("raw c0 pc_hold", 32'(bus0.pc_hold), 0);
    s.id_two_src = 1'b0;
    cycle(s);
    check("raw one-src c1 pc_hold", 32'(bus1.pc_hold), 0);

    // branch kills a simultaneous hazard
    s = load_use(5'd9); s.br_taken = 1'b1;
    cycle(s);
    check("br c0 ifid_flush", 32'(bus0.ifid_flush), 1);
    check("br c0 pc_hold", 32'(bus0.pc_hold), 0);
    cycle(idle());
    check("br c0 cnt_flush", bus0.cnt_flush, 1);
    check("br c0 cnt_stall", bus0.cnt_stall, 1);

    // memory wait of 4 cycles, branch pulse mid-wait
    s = idle(); s.cnt_clr = 1'b1;
    cycle(s);
    s = idle(); s.mem_req = 1'b1;
    cycle(s);
    s.br_taken = 1'b1;
    cycle(s);
    check("mw br c0 ifid_flush", 32'(bus0.ifid_flush), 0);
    s.br_taken = 1'b0;
    cycle(s);
    s.mem_ready = 1'b1;
    cycle(s);
    check("mw last c0 freeze", 32'(bus0.freeze), 1);
    cycle(idle());
    check("mw after c0 freeze", 32'(bus0.freeze), 0);
    check("mw c0 cnt_memwait", bus0.cnt_memwait, 4);
    check("mw c1 cnt_memwait", bus1.cnt_memwait, 4);
    check("mw c0 cnt_flush", bus0.cnt_flush, 0);

    // timeout: cfg 0 after 4 waits, cfg 1 after 7 waits
    s = idle(); s.mem_req = 1'b1;
    for (int i = 0; i < 5; i++) cycle(s);
    cycle(idle());
    check("tmo c0 flag", 32'(bus0.mem_timeout), 1);
    check("tmo c0 freeze", 32'(bus0.freeze), 0);
    check("tmo c0 state", 32'(bus0.state_dbg), 0);
    check("tmo c1 flag early", 32'(bus1.mem_timeout), 0);
    cycle(idle());
    cycle(idle());
    cycle(idle());
    check("tmo c1 flag", 32'(bus1.mem_timeout), 1);
    check("tmo c1 freeze", 32'(bus1.freeze), 0);
    s = idle(); s.cnt_clr = 1'b1;
    cycle(s);
    cycle(idle());
    check("tmo c0 survives clr", 32'(bus0.mem_timeout), 1);

    // saturation: 20 stall cycles
    s = idle(); s.cnt_clr = 1'b1;
    cycle(s);
    for (int i = 0; i < 20; i++) cycle(load_use(5'd3));
    cycle(idle());
    check("sat c0 cnt_stall", bus0.cnt_stall, 15);
    check("sat c1 cnt_stall", bus1.cnt_stall, 20);

    // asynchronous reset in the middle of a memory wait
    s = idle(); s.mem_req = 1'b1;
    for (int i = 0; i < 3; i++) cycle(s);
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("arst c0 freeze", 32'(bus0.freeze), 0);
    check("arst c1 freeze", 32'(bus1.freeze), 0);
    check("arst c0 cnt_memwait", bus0.cnt_memwait, 0);
    check("arst c1 cnt_stall", bus1.cnt_stall, 0);
    check("arst c0 mem_timeout", 32'(bus0.mem_timeout), 0);
    check("arst c0 state", 32'(bus0.state_dbg), 0);
    model_reset(0);
    model_reset(1);
    s.rst = 1'b0;
    cycle(s);
    cycle(idle());

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) cycle(rand_stim());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
